// File: rtl/div_iter_if.sv
// rtl/div_iter_if.sv - EX-to-divider request/result bundle
interface div_iter_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_iter.sv
// rtl/div_iter.sv - 32-step restoring divider returning {remainder, quotient}
module div_iter (
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_BYZERO,
    ST_ON,
    ST_END
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [31:0] divisor_q, divisor_d;
  logic [64:0] work_q, work_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [32:0] diff;
  logic [31:0] quo_raw;
  logic [31:0] rem_raw;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  logic        op_neg1;
  logic        op_neg2;

  assign op_neg1      = bus.signed_div_i & bus.opdata1_i[31];
  assign op_neg2      = bus.signed_div_i & bus.opdata2_i[31];
  assign dividend_abs = op_neg1 ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
  assign divisor_abs  = op_neg2 ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

  // Trial subtraction; bit 32 set means the partial remainder is below the divisor.
  assign diff    = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
  assign quo_raw = work_q[31:0];
  assign rem_raw = work_q[64:33];
  assign quo_fix = (neg1_q ^ neg2_q) ? (~quo_raw + 32'd1) : quo_raw;
  assign rem_fix = neg1_q ? (~rem_raw + 32'd1) : rem_raw;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    divisor_d = divisor_q;
    work_d    = work_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      ST_FREE: begin
        ready_d  = 1'b0;
        result_d = 64'd0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == 32'd0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d   = ST_ON;
            cnt_d     = 6'd0;
            neg1_d    = op_neg1;
            neg2_d    = op_neg2;
            divisor_d = divisor_abs;
            work_d    = {32'd0, dividend_abs, 1'b0};
          end
        end
      end

      ST_BYZERO: begin
        state_d  = ST_END;
        result_d = 64'd0;
        ready_d  = 1'b1;
      end

      ST_ON: begin
        if (bus.annul_i) begin
          state_d  = ST_FREE;
          cnt_d    = 6'd0;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end else if (cnt_q < 6'd32) begin
          if (diff[32]) begin
            work_d = {work_q[63:0], 1'b0};
          end else begin
            work_d = {diff[31:0], work_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          state_d  = ST_END;
        end
      end

      ST_END: begin
        // Result is already committed to EX, so annul has no say here.
        if (!bus.start_i) begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end
      end

      default: begin
        state_d = ST_FREE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= 6'd0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      divisor_q <= 32'd0;
      work_q    <= 65'd0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      divisor_q <= divisor_d;
      work_q    <= work_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
